aes_sector_sequencer: RTL and testbench
=======================================

# aes_sector_sequencer

Sequences one 512-byte SD sector through the shared AES decryption core, one 128-bit block at a time. Reads ciphertext from the sector buffer, launches the core, waits for completion and writes the plaintext back to the same buffer slot. It sits between the SD read path (sector buffer) and the AES decryption core. It owns the core's `decrypt` strobe and data input.

## Interface
- `BLOCKS`, 32: 128-bit blocks per sector.
- `ADDR_W`, 5: buffer address width; must satisfy 2^ADDR_W ≥ BLOCKS.
- `TIMEOUT_CYC`, 1023: maximum cycles to wait for the core per block.
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to process a sector. Ignored while `busy`=1.
- `busy` out 1: high from the cycle after `start` is accepted until `done` or `err`.
- `done` out 1: one-cycle pulse; the sector completed without error.
- `err` out 1: sticky timeout flag; cleared when the next `start` is accepted.
- `buf_rd_en` out 1: buffer read strobe. Read data returns the following cycle.
- `buf_addr` out ADDR_W: buffer block address, shared by reads and writes.
- `buf_rd_data` in 128: ciphertext block from the buffer.
- `buf_wr_en` out 1: buffer write strobe.
- `buf_wr_data` out 128: plaintext block to the buffer.
- `aes_din` out 128: ciphertext presented to the core; held stable from KICK to WAIT_HI inclusive.
- `aes_decrypt` out 1: one-cycle start pulse to the core.
- `aes_done` in 1: core done level. It stays high until the next `aes_decrypt` is sampled.
- `aes_dout` in 128: core plaintext; valid while `aes_done`=1.
- `iv` in 128: CBC initial vector, sampled when `start` is accepted (CBC_EN builds only).

## Operation
States: IDLE, READ, LATCH, KICK, WAIT_LO, WAIT_HI, WRITE, FIN.
- IDLE:
  - On `start`: `blk`←0, `err`←0, `chain`←`iv`, go to READ.
- READ:
  - `buf_rd_en`=1, `buf_addr`=`blk`. Go to LATCH.
- LATCH:
  - `cipher`←`buf_rd_data`. Go to KICK.
- KICK:
  - `aes_decrypt`=1, `aes_din`=`cipher`, wait counter←0. Go to WAIT_LO.
- WAIT_LO:
  - Wait for `aes_done`=0, which drops the stale done from the previous block. Then go to WAIT_HI.
- WAIT_HI:
  - Wait for `aes_done`=1, then `plain`←`aes_dout` (XOR `chain` if CBC_EN). Go to WRITE.
- WRITE:
  - `buf_wr_en`=1, `buf_addr`=`blk`, `buf_wr_data`=`plain`.
  - `chain`←`cipher`.
  - If `blk`=BLOCKS-1, go to FIN. Otherwise `blk`←`blk`+1 and go to READ.
- FIN:
  - `done`=1 for one cycle. Go to IDLE.
- Timeout:
  - The wait counter increments in each WAIT_LO/WAIT_HI cycle.
  - On reaching TIMEOUT_CYC: `err`←1, go to IDLE. Blocks already written stay written; no `done` pulse.
- `blk` is ADDR_W wide and never wraps past BLOCKS-1.
- `start` received in any state other than IDLE is dropped, not queued.

## Timing
- Reset (`reset_n`=0 at a clock edge) forces IDLE, `blk`=0, and all outputs 0, including `err` and the data buses. This applies mid-sector; an in-flight core operation is abandoned.
- Per block: 6 cycles of sequencer overhead plus the core latency measured from `aes_decrypt` to `aes_done` rising.
- `busy` rises the cycle after `start` and falls in the cycle `done` pulses or `err` sets.
- `aes_done` is already low in the first WAIT_LO cycle: WAIT_LO lasts exactly one cycle.
- `aes_done` is high in the first WAIT_HI cycle: the capture happens in that cycle.
- Write and read to the buffer are never issued in the same cycle.

## Configuration
- `AES_SEQ_CBC_EN` defined: CBC decryption.
  - `plain` = `aes_dout` XOR `chain`.
  - `chain` starts at `iv` and becomes each block's ciphertext after its write.
- `AES_SEQ_CBC_EN` undefined: ECB decryption.
  - `plain` = `aes_dout`.
  - `iv` port and `chain` register are absent.

## Test plan
- Reset mid-sector: `reset_n`=0 during WAIT_HI at block 5 -> next cycle `busy`=0, `buf_addr`=0, `err`=0. A subsequent `start` restarts from block 0.
- ECB sector:
  - Stimulus: buffer block i = i, core model with 20-cycle latency and dout = din XOR 128'hA5…A5.
  - Response: 32 writes; block i = i XOR A5…A5; `done` pulses once, 32×(6+20) cycles after `start`.
- CBC (CBC_EN):
  - Stimulus: iv=128'h1, same model.
  - Response: block0 = (0 XOR A5…A5) XOR 1; block k = (k XOR A5…A5) XOR (k-1).
- Stale done:
  - Stimulus: model holds `aes_done`=1 for 3 extra cycles after `aes_decrypt`.
  - Response: no capture until `aes_done` falls and then rises again.
- Timeout:
  - Stimulus: model never raises `aes_done` on block 3.
  - Response: `err`=1 and `busy`=0 after TIMEOUT_CYC cycles; blocks 0-2 are written; no `done` pulse.
- `start` held high for 10 cycles mid-sector -> ignored; exactly one sector processed, one `done` pulse.

Source files
------------

// File: rtl/aes_sector_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_sector_sequencer_if
// Bundles the control handshake, the sector-buffer port and the AES-core port
// of the sector sequencer.
//   master : sequencer side (drives busy/done/err, buffer strobes, core input)
//   slave  : environment side (drives start, read data, core results, iv)
// Signals:
//   start/busy/done/err          sector request and status
//   buf_rd_en/buf_wr_en/buf_addr buffer strobes and shared block address
//   buf_rd_data/buf_wr_data      ciphertext in, plaintext out
//   aes_din/aes_decrypt          core data input and start pulse
//   aes_done/aes_dout            core done level and plaintext
//   iv                           CBC initial vector (AES_SEQ_CBC_EN builds only)
// ---------------------------------------------------------------------------
interface aes_sector_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_addr;
    logic [127:0]      buf_rd_data;
    logic              buf_wr_en;
    logic [127:0]      buf_wr_data;
    logic [127:0]      aes_din;
    logic              aes_decrypt;
    logic              aes_done;
    logic [127:0]      aes_dout;
`ifdef AES_SEQ_CBC_EN
    logic [127:0]      iv;
`endif

    modport master (
`ifdef AES_SEQ_CBC_EN
        input  iv,
`endif
        input  start,
        output busy,
        output done,
        output err,
        output buf_rd_en,
        output buf_addr,
        input  buf_rd_data,
        output buf_wr_en,
        output buf_wr_data,
        output aes_din,
        output aes_decrypt,
        input  aes_done,
        input  aes_dout
    );

    modport slave (
`ifdef AES_SEQ_CBC_EN
        output iv,
`endif
        output start,
        input  busy,
        input  done,
        input  err,
        input  buf_rd_en,
        input  buf_addr,
        output buf_rd_data,
        input  buf_wr_en,
        input  buf_wr_data,
        input  aes_din,
        input  aes_decrypt,
        output aes_done,
        output aes_dout
    );
endinterface

// File: rtl/aes_sector_sequencer.sv
// ---------------------------------------------------------------------------
// aes_sector_sequencer
// Walks one SD sector (BLOCKS x 128-bit) through the shared AES decryption
// core: read a ciphertext block from the sector buffer, kick the core, wait
// for its result and write the plaintext back into the same buffer slot.
//
// Ports:
//   clock    single rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      aes_sector_sequencer_if.master (handshake, buffer, core)
//
// Build option:
//   AES_SEQ_CBC_EN  defined   -> CBC: plain = aes_dout ^ chain, chain starts
//                                at iv and follows each block's ciphertext.
//                   undefined -> ECB: plain = aes_dout, no iv / chain.
//
// All outputs come straight from registers; each state's outputs are loaded
// on the edge that enters that state.
// ---------------------------------------------------------------------------
module aes_sector_sequencer #(
    parameter int BLOCKS      = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                          clock,
    input  logic                          reset_n,
    aes_sector_sequencer_if.master        bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(BLOCKS - 1);
    localparam logic [ADDR_W-1:0] BLK_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Count value seen in the last permitted wait cycle.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LATCH   = 3'd2,
        S_KICK    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5,
        S_WRITE   = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] blk_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              buf_rd_en_r;
    logic              buf_wr_en_r;
    logic [ADDR_W-1:0] buf_addr_r;
    logic [127:0]      buf_wr_data_r;
    // Holds the current ciphertext from LATCH until the next block's LATCH,
    // so it doubles as the cipher register and stays stable on aes_din.
    logic [127:0]      aes_din_r;
    logic              aes_decrypt_r;
    logic [127:0]      plain_s;

`ifdef AES_SEQ_CBC_EN
    logic [127:0]      chain_r;
    assign plain_s = bus.aes_dout ^ chain_r;
`else
    assign plain_s = bus.aes_dout;
`endif

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            blk_r         <= {ADDR_W{1'b0}};
            wait_cnt_r    <= {CNT_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            buf_rd_en_r   <= 1'b0;
            buf_wr_en_r   <= 1'b0;
            buf_addr_r    <= {ADDR_W{1'b0}};
            buf_wr_data_r <= 128'h0;
            aes_din_r     <= 128'h0;
            aes_decrypt_r <= 1'b0;
`ifdef AES_SEQ_CBC_EN
            chain_r       <= 128'h0;
`endif
        end else begin
            // Single-cycle strobes drop unless the next state re-asserts them.
            buf_rd_en_r   <= 1'b0;
            buf_wr_en_r   <= 1'b0;
            aes_decrypt_r <= 1'b0;
            done_r        <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        blk_r       <= {ADDR_W{1'b0}};
                        err_r       <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef AES_SEQ_CBC_EN
                        chain_r     <= bus.iv;
`endif
                        buf_rd_en_r <= 1'b1;
                        buf_addr_r  <= {ADDR_W{1'b0}};
                        state_r     <= S_READ;
                    end else begin
                        state_r     <= S_IDLE;
                    end
                end
                S_READ: begin
                    state_r <= S_LATCH;
                end
                S_LATCH: begin
                    // Buffer data is valid in the cycle after the read strobe.
                    aes_din_r     <= bus.buf_rd_data;
                    aes_decrypt_r <= 1'b1;
                    state_r       <= S_KICK;
                end
                S_KICK: begin
                    wait_cnt_r <= {CNT_W{1'b0}};
                    state_r    <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    // A done left high by the previous block must fall first.
                    wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    if (!bus.aes_done) begin
                        state_r <= S_WAIT_HI;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT_LO;
                    end
                end
                S_WAIT_HI: begin
                    wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    if (bus.aes_done) begin
                        buf_wr_data_r <= plain_s;
                        buf_wr_en_r   <= 1'b1;
                        buf_addr_r    <= blk_r;
                        state_r       <= S_WRITE;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT_HI;
                    end
                end
                S_WRITE: begin
`ifdef AES_SEQ_CBC_EN
                    chain_r <= aes_din_r;
`endif
                    if (blk_r == LAST_BLK) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_FIN;
                    end else begin
                        blk_r       <= blk_r + BLK_ONE;
                        buf_addr_r  <= blk_r + BLK_ONE;
                        buf_rd_en_r <= 1'b1;
                        state_r     <= S_READ;
                    end
                end
                S_FIN: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.err         = err_r;
    assign bus.buf_rd_en   = buf_rd_en_r;
    assign bus.buf_wr_en   = buf_wr_en_r;
    assign bus.buf_addr    = buf_addr_r;
    assign bus.buf_wr_data = buf_wr_data_r;
    assign bus.aes_din     = aes_din_r;
    assign bus.aes_decrypt = aes_decrypt_r;

endmodule

// File: tb/tb_aes_sector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_sector_sequencer
// Scoreboard bench: each test pushes the buffer writes and done pulses it
// expects; a monitor pops and compares whenever the DUT writes or pulses done.
// Buffer block i holds the value i; the core model returns din ^ A5..A5.
// The core model raises aes_done LAT+1 edges after it samples aes_decrypt,
// which makes each block take 6 + LAT cycles end to end.
// ---------------------------------------------------------------------------
module tb_aes_sector_sequencer;

    localparam int           BLOCKS  = 32;
    localparam int           TMO     = 1023;
    localparam int           LAT     = 20;
    localparam int           PER_BLK = 6 + LAT;
    localparam logic [127:0] PAT     = {16{8'hA5}};
    localparam logic [127:0] IV      = 128'h1;

    typedef struct {
        logic [4:0]   addr;
        logic [127:0] data;
    } wr_t;

    logic clk;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   kicks = 0;
    int   last_kick_cyc = 0;
    int   stale_extra = 0;
    int   hang_kick = -1;
    int   cnt_m = 0;
    int   hold_m = 0;
    logic hang_m;
    logic [127:0] din_m;

    wr_t exp_q[$];
    int  exp_done[$];

    aes_sector_sequencer_if #(.ADDR_W(5)) bus ();

    aes_sector_sequencer #(
        .BLOCKS(BLOCKS),
        .ADDR_W(5),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clock(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sector buffer: block i holds i, data returned one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.buf_rd_en) bus.buf_rd_data <= 128'(bus.buf_addr);
    end

    // AES core model: done drops on decrypt (or after a stale hold), rises later.
    always @(posedge clk) begin
        if (!reset_n) begin
            bus.aes_done <= 1'b0;
            bus.aes_dout <= 128'h0;
            cnt_m        <= 0;
            hold_m       <= 0;
            hang_m       <= 1'b0;
        end else if (bus.aes_decrypt) begin
            kicks  <= kicks + 1;
            din_m  <= bus.aes_din;
            hang_m <= (kicks == hang_kick);
            cnt_m  <= LAT + 1;
            if (stale_extra > 0 && bus.aes_done) hold_m <= stale_extra;
            else bus.aes_done <= 1'b0;
        end else if (hold_m > 0) begin
            hold_m <= hold_m - 1;
            if (hold_m == 1) bus.aes_done <= 1'b0;
        end else if (cnt_m > 0) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1 && !hang_m) begin
                bus.aes_done <= 1'b1;
                bus.aes_dout <= din_m ^ PAT;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_plain(input int k);
        logic [127:0] p;
        p = 128'(k) ^ PAT;
`ifdef AES_SEQ_CBC_EN
        p = p ^ ((k == 0) ? IV : 128'(k - 1));
`endif
        return p;
    endfunction

    task automatic push_writes(input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.addr = 5'(k);
            e.data = exp_plain(k);
            exp_q.push_back(e);
        end
    endtask

    // Returns the cycle count at which start was driven.
    task automatic start_sector(output int k0);
        @(negedge clk);
        bus.start = 1'b1;
        k0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk({name, "_busy_falls"}, 128'(bus.busy), 128'h0);
        repeat (3) @(negedge clk);
        chk({name, "_writes_drained"}, 128'(exp_q.size()), 128'h0);
        chk({name, "_done_drained"}, 128'(exp_done.size()), 128'h0);
    endtask

    // Monitor: compare every buffer write and done pulse against the scoreboard.
    initial begin
        wr_t e;
        int  d;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.buf_wr_en || bus.buf_rd_en)
                    chk("rd_wr_exclusive", 128'(bus.buf_wr_en && bus.buf_rd_en), 128'h0);
                if (bus.buf_wr_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_addr", 128'(bus.buf_addr), 128'h1F_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 128'(bus.buf_addr), 128'(e.addr));
                        chk("write_data", bus.buf_wr_data, e.data);
                    end
                end
                if (bus.done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done_cycle", 128'(cyc), 128'h0);
                    end else begin
                        d = exp_done.pop_front();
                        if (d >= 0) chk("done_cycle", 128'(cyc), 128'(d));
                        chk("busy_low_with_done", 128'(bus.busy), 128'h0);
                    end
                end
                if (bus.aes_decrypt) last_kick_cyc = cyc;
            end
        end
    end

    initial begin
        int k0;
        int base;
        reset_n   = 1'b0;
        bus.start = 1'b0;
`ifdef AES_SEQ_CBC_EN
        bus.iv    = IV;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'h0);
        chk("rst_done", 128'(bus.done), 128'h0);
        chk("rst_err", 128'(bus.err), 128'h0);
        chk("rst_buf_addr", 128'(bus.buf_addr), 128'h0);
        chk("rst_strobes", 128'({bus.buf_rd_en, bus.buf_wr_en, bus.aes_decrypt}), 128'h0);
        chk("rst_aes_din", bus.aes_din, 128'h0);
        chk("rst_wr_data", bus.buf_wr_data, 128'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full sector with exact done timing.
        push_writes(BLOCKS);
        start_sector(k0);
        exp_done.push_back(k0 + 1 + BLOCKS * PER_BLK);
        chk("busy_after_start", 128'(bus.busy), 128'h1);
        wait_idle("sector", 2000);

        // start held high for 10 cycles mid-sector is ignored.
        push_writes(BLOCKS);
        start_sector(k0);
        exp_done.push_back(k0 + 1 + BLOCKS * PER_BLK);
        repeat (100) @(negedge clk);
        bus.start = 1'b1;
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        wait_idle("held_start", 2000);
        repeat (50) @(negedge clk);
        chk("held_start_no_restart", 128'(bus.busy), 128'h0);

        // Stale done: core keeps done high 3 cycles past each decrypt.
        stale_extra = 3;
        push_writes(BLOCKS);
        start_sector(k0);
        exp_done.push_back(-1);
        wait_idle("stale_done", 3000);
        stale_extra = 0;

        // Timeout: core never answers block 3.
        hang_kick = kicks + 3;
        push_writes(3);
        start_sector(k0);
        for (int i = 0; i < 2000; i++) begin
            if (bus.err) break;
            @(negedge clk);
        end
        chk("timeout_err", 128'(bus.err), 128'h1);
        chk("timeout_busy", 128'(bus.busy), 128'h0);
        chk("timeout_latency", 128'(cyc - last_kick_cyc), 128'(TMO + 1));
        repeat (20) @(negedge clk);
        chk("timeout_writes_0_2", 128'(exp_q.size()), 128'h0);
        chk("timeout_err_sticky", 128'(bus.err), 128'h1);
        hang_kick = -1;

        // Reset during WAIT_HI of block 5, then a clean restart.
        base = kicks;
        push_writes(5);
        start_sector(k0);
        chk("err_cleared_on_start", 128'(bus.err), 128'h0);
        for (int i = 0; i < 500; i++) begin
            if (kicks == base + 6) break;
            @(negedge clk);
        end
        chk("reached_block5", 128'(kicks), 128'(base + 6));
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 128'(bus.busy), 128'h0);
        chk("midrst_buf_addr", 128'(bus.buf_addr), 128'h0);
        chk("midrst_err", 128'(bus.err), 128'h0);
        chk("midrst_aes_din", bus.aes_din, 128'h0);
        chk("midrst_writes_0_4", 128'(exp_q.size()), 128'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        push_writes(BLOCKS);
        start_sector(k0);
        exp_done.push_back(k0 + 1 + BLOCKS * PER_BLK);
        wait_idle("restart", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
